// File: rtl/fwd_select_ctrl_if.sv
// Bundle between the ID-stage control and the forwarding/hazard controller.
// ID-side fields (id_*) are only meaningful while id_valid is high. There is no
// per-transfer ready: the controller consumes the ID record on every rising edge
// with pipe_hold low. With pipe_hold high, nothing is consumed and no state moves.
// stall is the controller's back-pressure. While it is high, the ID record is
// replaced by a bubble, and ID must present the same instruction again.
// stage_dbg exposes the EX/MEM/WB shadow records {vld, wr, wd, load}, with EX
// in the most significant field.
interface fwd_select_ctrl_if #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
);
  logic                      pipe_hold;
  logic                      id_flush;
  logic                      id_valid;
  logic [REG_ADDR_W-1:0]     id_rs;
  logic                      id_rs_used;
  logic [REG_ADDR_W-1:0]     id_rt;
  logic                      id_rt_used;
  logic                      id_wr_en;
  logic [REG_ADDR_W-1:0]     id_wd;
  logic                      id_is_load;
  logic [2:0]                fwd_a_sel;
  logic [2:0]                fwd_b_sel;
  logic                      stall;
  logic [CNT_W-1:0]          stall_cnt;
  logic [3*(REG_ADDR_W+3)-1:0] stage_dbg;

  // Pipeline control side: drives the ID record, receives selects and stall.
  modport master (
    output pipe_hold, id_flush, id_valid, id_rs, id_rs_used, id_rt, id_rt_used,
           id_wr_en, id_wd, id_is_load,
    input  fwd_a_sel, fwd_b_sel, stall, stall_cnt, stage_dbg
  );

  // Forwarding controller side.
  modport slave (
    input  pipe_hold, id_flush, id_valid, id_rs, id_rs_used, id_rt, id_rt_used,
           id_wr_en, id_wd, id_is_load,
    output fwd_a_sel, fwd_b_sel, stall, stall_cnt, stage_dbg
  );
endinterface

// File: rtl/fwd_select_ctrl.sv
// Forwarding / load-use hazard controller for the EX-stage operand muxes.
// Select codes: 0 = register file, 1 = EX/MEM result, 2 = MEM/WB result.
// The controller keeps shadow destination records for EX, MEM and WB. It
// computes the selects while the consumer is in ID and registers them, so they
// line up with the instruction when it reaches EX.
// Optional feature macro: FWD_PERF_CNT_EN adds a saturating stall-cycle counter.
// Without the macro, stall_cnt is tied to zero and no counter is built.
module fwd_select_ctrl #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  fwd_select_ctrl_if.slave   bus
);

  typedef struct packed {
    logic                  vld;
    logic                  wr;
    logic [REG_ADDR_W-1:0] wd;
    logic                  load;
  } stage_rec_t;

  localparam logic [2:0] SEL_RF  = 3'd0;
  localparam logic [2:0] SEL_MEM = 3'd1;
  localparam logic [2:0] SEL_WB  = 3'd2;

  stage_rec_t ex_q;
  stage_rec_t mem_q;
  stage_rec_t wb_q;
  stage_rec_t id_rec;

  logic [2:0] a_sel_d;
  logic [2:0] b_sel_d;
  logic [2:0] a_sel_q;
  logic [2:0] b_sel_q;
  logic       hit_a;
  logic       hit_b;
  logic       stall_w;
  logic       bubble;

  // Pick the forwarding source for one operand. The nearest older producer wins.
  // A load sitting in EX is skipped because its data only exists at MEM/WB.
  // That case is covered by the stall, which separates the two instructions with
  // a bubble so that the load is found in MEM on the retry.
  function automatic logic [2:0] pick_sel(
    input logic                  used,
    input logic [REG_ADDR_W-1:0] src,
    input stage_rec_t            ex,
    input stage_rec_t            mem
  );
    logic [2:0] sel;
    sel = SEL_RF;
    if (!used || (src == '0)) begin
      sel = SEL_RF;
    end else if (ex.vld && ex.wr && (ex.wd == src) && !ex.load) begin
      sel = SEL_MEM;
    end else if (mem.vld && mem.wr && (mem.wd == src)) begin
      sel = SEL_WB;
    end else begin
      sel = SEL_RF;
    end
    return sel;
  endfunction

  // Load-use detection against the instruction currently in EX. A flushed or
  // empty ID slot never stalls, so flush wins over stall.
  always_comb begin
    hit_a   = bus.id_rs_used && (bus.id_rs == ex_q.wd);
    hit_b   = bus.id_rt_used && (bus.id_rt == ex_q.wd);
    stall_w = bus.id_valid && !bus.id_flush &&
              ex_q.vld && ex_q.wr && ex_q.load && (ex_q.wd != '0) &&
              (hit_a || hit_b);
  end

  // Build the record that would enter EX. A write to register 0 is recorded as
  // no write, so r0 can never be a forwarding source.
  always_comb begin
    id_rec      = '0;
    id_rec.vld  = 1'b1;
    id_rec.wr   = bus.id_wr_en && (bus.id_wd != '0);
    id_rec.wd   = bus.id_wd;
    id_rec.load = bus.id_is_load;
    bubble      = stall_w || bus.id_flush || !bus.id_valid;
  end

  // Next-cycle operand selects for the instruction now in ID.
  always_comb begin
    a_sel_d = pick_sel(bus.id_rs_used, bus.id_rs, ex_q, mem_q);
    b_sel_d = pick_sel(bus.id_rt_used, bus.id_rt, ex_q, mem_q);
  end

  // Shadow pipeline: WB <= MEM <= EX <= ID (or a bubble). Frozen while held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else if (!bus.pipe_hold) begin
      wb_q  <= mem_q;
      mem_q <= ex_q;
      ex_q  <= bubble ? stage_rec_t'('0) : id_rec;
    end
  end

  // Registered selects that travel with the record into EX. Bubbles read the regfile.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sel_q <= SEL_RF;
      b_sel_q <= SEL_RF;
    end else if (!bus.pipe_hold) begin
      a_sel_q <= bubble ? SEL_RF : a_sel_d;
      b_sel_q <= bubble ? SEL_RF : b_sel_d;
    end
  end

`ifdef FWD_PERF_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  // Count real stall cycles, meaning those not frozen by pipe_hold. The count
  // saturates at all-ones and only reset clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (stall_w && !bus.pipe_hold && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign bus.stall_cnt = cnt_q;
`else
  assign bus.stall_cnt = '0;
`endif

  assign bus.fwd_a_sel = a_sel_q;
  assign bus.fwd_b_sel = b_sel_q;
  assign bus.stall     = stall_w;
  assign bus.stage_dbg = {ex_q, mem_q, wb_q};

  // Codes 3..7 are reserved and must never reach the muxes.
  a_sel_range: assert property (@(posedge clk) disable iff (!rst_n)
    (a_sel_q <= SEL_WB) && (b_sel_q <= SEL_WB));

  // A flushed ID slot must never raise a stall.
  flush_no_stall: assert property (@(posedge clk) disable iff (!rst_n)
    bus.id_flush |-> !stall_w);

endmodule

// File: tb/tb_fwd_select_ctrl.sv
// Directed and random checks of fwd_select_ctrl. Expected selects are pushed
// when an ID instruction is driven and popped once that instruction reaches EX.
module tb_fwd_select_ctrl;
  localparam int RW = 5;
  localparam int CW = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  fwd_select_ctrl_if #(.REG_ADDR_W(RW), .CNT_W(CW)) bus();

  fwd_select_ctrl #(.REG_ADDR_W(RW), .CNT_W(CW)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int exp_stalls = 0;
  logic [5:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic drive_id(input logic vld, input logic flush,
                          input int rs, input logic rs_u, input int rt, input logic rt_u,
                          input logic wr, input int wd, input logic ld);
    bus.id_valid   = vld;
    bus.id_flush   = flush;
    bus.id_rs      = rs[RW-1:0];
    bus.id_rs_used = rs_u;
    bus.id_rt      = rt[RW-1:0];
    bus.id_rt_used = rt_u;
    bus.id_wr_en   = wr;
    bus.id_wd      = wd[RW-1:0];
    bus.id_is_load = ld;
  endtask

  task automatic pop_and_check(input string tag);
    logic [5:0] e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check_eq({tag, "/a_sel"}, bus.fwd_a_sel, e[5:3]);
      check_eq({tag, "/b_sel"}, bus.fwd_b_sel, e[2:0]);
    end
  endtask

  // Entered just after a rising edge; returns just after the next one.
  task automatic issue(input string tag, input logic vld, input logic flush,
                       input int rs, input logic rs_u, input int rt, input logic rt_u,
                       input logic wr, input int wd, input logic ld,
                       input int exp_a, input int exp_b, input logic exp_stall);
    logic [2:0] ea;
    logic [2:0] eb;
    ea = exp_a[2:0];
    eb = exp_b[2:0];
    drive_id(vld, flush, rs, rs_u, rt, rt_u, wr, wd, ld);
    exp_q.push_back({ea, eb});
    #1;
    check_eq({tag, "/stall"}, bus.stall, exp_stall);
    if (exp_stall) exp_stalls++;
    @(posedge clk);
    #1;
    pop_and_check(tag);
  endtask

  task automatic nop(input string tag);
    issue(tag, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 0, 1'b0, 0, 0, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < 3; i++) nop("drain");
  endtask

  task automatic check_cnt(input string tag);
`ifdef FWD_PERF_CNT_EN
    check_eq(tag, bus.stall_cnt, exp_stalls);
`else
    check_eq(tag, bus.stall_cnt, 0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.pipe_hold = 1'b0;
    drive_id(1'b0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 0, 1'b0);

    // Clock and reset.
    #12;
    check_eq("rst/a_sel", bus.fwd_a_sel, 0);
    check_eq("rst/b_sel", bus.fwd_b_sel, 0);
    check_eq("rst/stall", bus.stall, 0);
    check_eq("rst/cnt", bus.stall_cnt, 0);
    check_eq("rst/dbg", bus.stage_dbg, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Back-to-back RAW: add $3 ; add $4,$3,$5.
    issue("c2_prod", 1, 0, 1, 1, 2, 1, 1, 3, 0, 0, 0, 0);
    issue("c2_cons", 1, 0, 3, 1, 5, 1, 1, 4, 0, 1, 0, 0);
    drain();

    // Distance-two RAW, then nearest producer wins.
    issue("c3_prod", 1, 0, 1, 1, 2, 1, 1, 3, 0, 0, 0, 0);
    nop("c3_gap");
    issue("c3_sub", 1, 0, 5, 1, 3, 1, 1, 6, 0, 0, 2, 0);
    issue("c3_p1", 1, 0, 1, 1, 2, 1, 1, 3, 0, 0, 0, 0);
    issue("c3_p2", 1, 0, 1, 1, 2, 1, 1, 3, 0, 0, 0, 0);
    issue("c3_near", 1, 0, 3, 1, 3, 1, 1, 9, 0, 1, 1, 0);
    drain();

    // Load-use: lw $7,0($2) ; add $8,$7,$7 -> one stall, then sel 2.
    issue("c4_add2", 1, 0, 1, 1, 1, 1, 1, 2, 0, 0, 0, 0);
    issue("c4_lw", 1, 0, 2, 1, 0, 0, 1, 7, 1, 1, 0, 0);
    issue("c4_stall", 1, 0, 7, 1, 7, 1, 1, 8, 0, 0, 0, 1);
    issue("c4_retry", 1, 0, 7, 1, 7, 1, 1, 8, 0, 2, 2, 0);
    drain();
    check_cnt("c4/cnt");

    // Flush beats stall; r0 never forwards.
    issue("c5_lw", 1, 0, 1, 0, 0, 0, 1, 7, 1, 0, 0, 0);
    issue("c5_flush", 1, 1, 7, 1, 7, 1, 1, 8, 0, 0, 0, 0);
    issue("c5_after", 1, 0, 8, 1, 8, 1, 1, 10, 0, 0, 0, 0);
    issue("c5_wr0", 1, 0, 1, 1, 2, 1, 1, 0, 0, 0, 0, 0);
    check_eq("c5/wd0_rec", bus.stage_dbg[3*(RW+3)-1 -: (RW+3)], 8'h80);
    issue("c5_use0", 1, 0, 0, 1, 0, 1, 1, 11, 0, 0, 0, 0);
    drain();

    // Load-use with a three-cycle freeze in the middle.
    issue("c6_add2", 1, 0, 1, 1, 1, 1, 1, 2, 0, 0, 0, 0);
    issue("c6_lw", 1, 0, 2, 1, 0, 0, 1, 7, 1, 1, 0, 0);
    drive_id(1, 0, 7, 1, 7, 1, 1, 8, 0);
    bus.pipe_hold = 1'b1;
    #1;
    check_eq("c6/hold_stall0", bus.stall, 1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check_eq("c6/hold_stall", bus.stall, 1);
      check_eq("c6/hold_a", bus.fwd_a_sel, 1);
      check_eq("c6/hold_b", bus.fwd_b_sel, 0);
      check_eq("c6/hold_ex", bus.stage_dbg[3*(RW+3)-1 -: (RW+3)], 8'hCF);
    end
    check_cnt("c6/hold_cnt");
    bus.pipe_hold = 1'b0;
    issue("c6_stall", 1, 0, 7, 1, 7, 1, 1, 8, 0, 0, 0, 1);
    issue("c6_retry", 1, 0, 7, 1, 7, 1, 1, 8, 0, 2, 2, 0);
    drain();
    check_cnt("c6/cnt");

    // Random independent traffic: sources 1..15, destinations 16..31, no hits.
    for (int i = 0; i < 24; i++) begin
      issue("rnd", 1'($urandom_range(0, 1)), 1'b0,
            int'($urandom_range(1, 15)), 1'($urandom_range(0, 1)),
            int'($urandom_range(1, 15)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), int'($urandom_range(16, 31)),
            1'($urandom_range(0, 1)), 0, 0, 1'b0);
    end
    drain();

    // Asynchronous reset mid-stream with forwards and a stall pending.
    issue("c1_prod", 1, 0, 1, 1, 2, 1, 1, 3, 0, 0, 0, 0);
    issue("c1_cons", 1, 0, 3, 1, 3, 1, 1, 4, 0, 1, 1, 0);
    issue("c1_lw", 1, 0, 4, 1, 0, 0, 1, 5, 1, 1, 0, 0);
    drive_id(1, 0, 5, 1, 0, 0, 1, 6, 0);
    #1;
    check_eq("c1/pre_stall", bus.stall, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("c1/rst_a", bus.fwd_a_sel, 0);
    check_eq("c1/rst_b", bus.fwd_b_sel, 0);
    check_eq("c1/rst_stall", bus.stall, 0);
    check_eq("c1/rst_dbg", bus.stage_dbg, 0);
    exp_stalls = 0;
    check_cnt("c1/rst_cnt");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    issue("c1_post", 1, 0, 3, 1, 5, 1, 1, 6, 0, 0, 0, 0);
    issue("c1_post2", 1, 0, 4, 1, 5, 1, 1, 7, 0, 0, 0, 0);
    nop("c1_end");

    check_eq("sb_drain", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
